// File: rtl/fp_divider.sv
// fp_divider: restoring signed fixed-point divider out=A/B in WIO.WFO; start/busy/done handshake, overflow on range or B==0; FPDIV_SATURATE_EN selects saturating overflow output
module fp_divider #(
  parameter int WI1 = 8,
  parameter int WF1 = 10,
  parameter int WI2 = 8,
  parameter int WF2 = 10,
  parameter int WIO = 9,
  parameter int WFO = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WI1+WF1-1:0]     A,
  input  logic [WI2+WF2-1:0]     B,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [WIO+WFO-1:0]     out
);
  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;
  localparam int NW = WA + WF2 + WFO;
  localparam int DW = WB + WF1;
  localparam int WO = WIO + WFO;
  localparam int CW = $clog2(NW);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [NW-1:0] QLIM = NW'(1) << (WO - 1);
  localparam logic [WO-1:0] POS_SAT = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] NEG_SAT = {1'b1, {(WO-1){1'b0}}};
  logic [1:0] state;
  logic sign;
  logic [NW-1:0] num, quo, quo_nx, q_signed;
  logic [DW-1:0] den, rem, rem_nx;
  logic [DW:0] rem_sh;
  logic [CW-1:0] cnt;
  logic [WA-1:0] abs_a;
  logic [WB-1:0] abs_b;
  logic ge, ovf_nx;
  logic [WO-1:0] res, dbz_out;
  assign abs_a = A[WA-1] ? -A : A;
  assign abs_b = B[WB-1] ? -B : B;
  assign rem_sh = {rem, num[NW-1]};
  assign ge = rem_sh >= {1'b0, den};
  assign rem_nx = ge ? DW'(rem_sh - {1'b0, den}) : rem_sh[DW-1:0];
  assign quo_nx = {quo[NW-2:0], ge};
  assign ovf_nx = sign ? (quo_nx > QLIM) : (quo_nx >= QLIM);
  assign q_signed = sign ? -quo_nx : quo_nx;
`ifdef FPDIV_SATURATE_EN
  assign res = ovf_nx ? (sign ? NEG_SAT : POS_SAT) : q_signed[WO-1:0];
  assign dbz_out = A[WA-1] ? NEG_SAT : POS_SAT;
`else
  assign res = q_signed[WO-1:0];
  assign dbz_out = '0;
`endif
  assign busy = state == CALC;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        sign <= A[WA-1] ^ B[WB-1];
        num <= NW'(abs_a) << (WF2 + WFO);
        den <= DW'(abs_b) << WF1;
        rem <= '0;
        quo <= '0;
        cnt <= '0;
        state <= (B == '0) ? DONE : CALC;
        if (B == '0) begin
          out <= dbz_out;
          overflow <= 1'b1;
        end
      end
    end else if (state == CALC) begin
      num <= num << 1;
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(NW - 1)) begin
        state <= DONE;
        out <= res;
        overflow <= ovf_nx;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_fp_divider;
  localparam int NW = 38;
`ifdef FPDIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [18:0] q;
    logic ovf;
    int lat;
    int nbusy;
    int t0;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [17:0] A = '0, B = '0;
  logic busy, done, overflow;
  logic [18:0] out;
  int cyc = 0, bcnt = 0, n_cmp = 0, n_err = 0;
  exp_t sbq[$];
  fp_divider dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .overflow(overflow), .out(out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) bcnt = 0;
    else if (busy) bcnt++;
    if (done) begin
      if (sbq.size() == 0) ck("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        ck("out", 32'(out), 32'(e.q));
        ck("overflow", 32'(overflow), 32'(e.ovf));
        ck("latency", 32'(cyc - e.t0), 32'(e.lat));
        ck("busy_cycles", 32'(bcnt), 32'(e.nbusy));
      end
      bcnt = 0;
    end
  end
  task automatic issue(input logic [17:0] a, input logic [17:0] b, input logic [18:0] qs,
                       input logic [18:0] qw, input logic o, input bit push);
    int t = 0;
    exp_t e;
    while ((busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) ck("idle_timeout", 32'd1, 32'd0);
    A = a;
    B = b;
    start = 1'b1;
    e.q = SAT ? qs : qw;
    e.ovf = o;
    e.lat = (b == '0) ? 1 : NW + 1;
    e.nbusy = (b == '0) ? 0 : NW;
    e.t0 = cyc;
    if (push) sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    int t;
    repeat (3) @(negedge clk);
    ck("rst_out", 32'(out), 32'd0);
    ck("rst_overflow", 32'(overflow), 32'd0);
    ck("rst_busy", 32'(busy), 32'd0);
    ck("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(18'h01800, 18'h00600, 19'h01000, 19'h01000, 1'b0, 1'b1);
    issue(18'(-7680), 18'd2048, 19'(-3840), 19'(-3840), 1'b0, 1'b1);
    issue(18'd1024, 18'd3072, 19'd341, 19'd341, 1'b0, 1'b1);
    issue(18'd130048, 18'd256, 19'h3FFFF, 19'h7F000, 1'b1, 1'b1);
    issue(18'(-131072), 18'd512, 19'h40000, 19'h40000, 1'b0, 1'b1);
    issue(18'(-131072), 18'd256, 19'h40000, 19'h00000, 1'b1, 1'b1);
    issue(18'd65536, 18'd256, 19'h3FFFF, 19'h40000, 1'b1, 1'b1);
    issue(18'd5120, 18'd0, 19'h3FFFF, 19'h00000, 1'b1, 1'b1);
    issue(18'(-1024), 18'd0, 19'h40000, 19'h00000, 1'b1, 1'b1);
    issue(18'd1, 18'(-3072), 19'd0, 19'd0, 1'b0, 1'b1);
    issue(18'(-512), 18'(-256), 19'd2048, 19'd2048, 1'b0, 1'b1);
    issue(18'(-131072), 18'(-131072), 19'd1024, 19'd1024, 1'b0, 1'b1);
    issue(18'h01800, 18'h00600, 19'h01000, 19'h01000, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    A = 18'd1024;
    B = 18'd3072;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    issue(18'd130048, 18'd256, 19'h3FFFF, 19'h7F000, 1'b1, 1'b1);
    issue(18'h01800, 18'h00600, 19'h01000, 19'h01000, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ck("midrst_out", 32'(out), 32'd0);
    ck("midrst_overflow", 32'(overflow), 32'd0);
    ck("midrst_busy", 32'(busy), 32'd0);
    ck("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    issue(18'd1024, 18'd3072, 19'd341, 19'd341, 1'b0, 1'b1);
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) ck("drain_timeout", 32'd1, 32'd0);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
